// File: rtl/uart_tx_frame_pkg.sv
// Shared constants and types for the parametrised UART transmitter:
// FSM encodings, parity modes, legal parameter ranges and the holding-buffer word.
package uart_tx_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned CLKS_PER_BIT_MIN = 2;
  localparam int unsigned DATA_BITS_MIN    = 5;
  localparam int unsigned DATA_BITS_MAX    = 9;
  localparam int unsigned STOP_BITS_MIN    = 1;
  localparam int unsigned STOP_BITS_MAX    = 2;

  // Wide enough to index any legal data width.
  localparam int unsigned IDX_W = 4;

  // Data is zero-extended to the widest legal word; unused upper bits stay 0.
  typedef struct packed {
    logic                     par;
    logic [DATA_BITS_MAX-1:0] data;
  } tx_word_t;

  function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
    return odd ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks on the last cycle of each serial bit and wraps to 0.
// The long period covers all stop bits in one go.
module uart_baud_cnt
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_clear,
  input  logic i_long,
  output logic o_tick
);

  localparam int unsigned CntMax = CLKS_PER_BIT * STOP_BITS;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] LastShort = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] LastLong  = CntW'(CntMax - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == (i_long ? LastLong : LastShort));
  assign o_tick  = !i_clear && at_last;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clear || at_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding buffer (valid/ready).
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_DV,
  input  logic [DATA_BITS-1:0] i_BYTE,
  output logic                 o_READY,
  output logic                 o_SERIAL,
  output logic                 o_BUSY,
  output logic                 o_DONE
);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : gen_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= %0d", CLKS_PER_BIT_MIN);
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : gen_bad_data
    $error("uart_tx_frame: DATA_BITS must be %0d..%0d", DATA_BITS_MIN, DATA_BITS_MAX);
  end
  if (PARITY > PARITY_EVEN) begin : gen_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : gen_bad_stop
    $error("uart_tx_frame: STOP_BITS must be %0d..%0d", STOP_BITS_MIN, STOP_BITS_MAX);
  end

  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(DATA_BITS - 1);
  localparam logic             HasParity = (PARITY != PARITY_NONE);
  localparam logic             OddParity = (PARITY == PARITY_ODD);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  tx_word_t         frame_q, frame_d;
  tx_word_t         buf_q, buf_d;
  logic             full_q, full_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;

  tx_word_t new_word;
  logic     xfer;
  logic     load;
  logic     bit_tick;
  logic     cnt_clear;
  logic     cnt_long;

  assign xfer      = i_DV && !full_q;
  assign cnt_clear = (state_q == ST_IDLE);
  assign cnt_long  = (state_q == ST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .STOP_BITS   (STOP_BITS)
  ) u_baud_cnt (
    .i_CLK  (i_CLK),
    .i_RST_N(i_RST_N),
    .i_clear(cnt_clear),
    .i_long (cnt_long),
    .o_tick (bit_tick)
  );

  // Parity is fixed at transfer time so the shifter never recomputes it.
  always_comb begin
    new_word                      = '0;
    new_word.data[DATA_BITS-1:0] = i_BYTE;
    new_word.par                  = HasParity ? calc_parity(new_word.data, OddParity) : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    buf_d   = buf_q;
    full_d  = full_q;
    done_d  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load = full_q;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = HasParity ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          done_d = 1'b1;
          if (full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Load first so a same-cycle transfer leaves the buffer full with the new word.
    if (load) begin
      frame_d = buf_q;
      full_d  = 1'b0;
      state_d = ST_START;
    end
    if (xfer) begin
      buf_d  = new_word;
      full_d = 1'b1;
    end

    // Line value follows the next state so o_SERIAL is a clean register.
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = frame_d.data[idx_d];
      ST_PARITY: serial_d = frame_d.par;
      default:   serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      frame_q  <= '0;
      buf_q    <= '0;
      full_q   <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign o_READY  = !full_q;
  assign o_SERIAL = serial_q;
  assign o_BUSY   = (state_q != ST_IDLE);
  assign o_DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: 8N1, 7E2 and 7O2 instances at 4 clocks per bit,
// checked against a frame model built from the line-format rules and a decoding scoreboard.
module tb_uart_tx_frame;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       dv_a = 1'b0;
  logic [7:0] byte_a = '0;
  logic       ready_a, ser_a, busy_a, done_a;
  logic       dv_b = 1'b0;
  logic [6:0] byte_b = '0;
  logic       ready_b, ser_b, busy_b, done_b;
  logic       ready_c, ser_c, busy_c, done_c;

  uart_tx_frame #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_DV(dv_a), .i_BYTE(byte_a),
    .o_READY(ready_a), .o_SERIAL(ser_a), .o_BUSY(busy_a), .o_DONE(done_a)
  );
  uart_tx_frame #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_7e2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_DV(dv_b), .i_BYTE(byte_b),
    .o_READY(ready_b), .o_SERIAL(ser_b), .o_BUSY(busy_b), .o_DONE(done_b)
  );
  uart_tx_frame #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut_7o2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_DV(dv_b), .i_BYTE(byte_b),
    .o_READY(ready_c), .o_SERIAL(ser_c), .o_BUSY(busy_c), .o_DONE(done_c)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic cap_ser_a[256], cap_busy_a[256], cap_done_a[256], cap_ready_a[256];
  logic cap_ser_b[256], cap_busy_b[256], cap_done_b[256];
  logic cap_ser_c[256], cap_busy_c[256], cap_done_c[256];

  // Line bits in transmit order: start, data LSB first, parity (total ones odd/even), stops.
  function automatic logic [15:0] frame_model(input logic [8:0] data, input int nbits,
                                              input int par, input int stops);
    logic [15:0] v;
    int ones;
    v = '1;
    v[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      v[1+i] = data[i];
      if (data[i]) ones++;
    end
    if (par == 1) v[1+nbits] = ((ones % 2) == 0);
    if (par == 2) v[1+nbits] = ((ones % 2) == 1);
    if (stops == 0) v = '0;
    return v;
  endfunction

  function automatic int frame_len(input int nbits, input int par, input int stops);
    return 1 + nbits + ((par != 0) ? 1 : 0) + stops;
  endfunction

  // Records all outputs for ncyc cycles; optionally drops dv after the first cycle.
  task automatic capture(input int ncyc, input bit pulse_a, input bit pulse_b);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      cap_ser_a[k] = ser_a; cap_busy_a[k] = busy_a; cap_done_a[k] = done_a;
      cap_ready_a[k] = ready_a;
      cap_ser_b[k] = ser_b; cap_busy_b[k] = busy_b; cap_done_b[k] = done_b;
      cap_ser_c[k] = ser_c; cap_busy_c[k] = busy_c; cap_done_c[k] = done_c;
      @(posedge clk); #1;
      if (k == 0 && pulse_a) dv_a = 1'b0;
      if (k == 0 && pulse_b) dv_b = 1'b0;
    end
  endtask

  // Frame decoder on the 8N1 line plus accepted-word log.
  logic [7:0] acc_q[$];
  logic [7:0] dec_q[$];
  bit         mon_busy = 1'b0;
  int         mon_cyc = 0;
  int         frame_err = 0;
  logic [7:0] mon_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 1'b0;
      end else begin
        if (dv_a && ready_a) acc_q.push_back(byte_a);
        if (!mon_busy) begin
          if (ser_a === 1'b0) begin
            mon_busy = 1'b1;
            mon_cyc = 0;
          end
        end else begin
          mon_cyc++;
        end
        if (mon_busy && (mon_cyc % Cpb) == Cpb / 2) begin
          if (mon_cyc / Cpb >= 1 && mon_cyc / Cpb <= 8) begin
            mon_data[mon_cyc/Cpb-1] = ser_a;
          end else if (mon_cyc / Cpb == 9) begin
            if (ser_a !== 1'b1) frame_err++;
            dec_q.push_back(mon_data);
          end
        end
        if (mon_busy && mon_cyc == 10 * Cpb - 1) mon_busy = 1'b0;
      end
    end
  end

  task automatic test_reset();
    int lows, busys, notready;
    rst_n = 1'b0; dv_a = 1'b1; byte_a = 8'h5A; dv_b = 1'b1; byte_b = 7'h2A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ser_a !== 1'b1) $display("FAIL reset_serial: got %b want 1", ser_a);
    else n_pass++;
    n_checks++;
    if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_a);
    else n_pass++;
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a);
    else n_pass++;
    n_checks++;
    if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a);
    else n_pass++;
    n_checks++;
    if ({ser_b, ser_c, ready_b, ready_c, busy_b, busy_c, done_b, done_c} !== 8'b1111_0000)
      $display("FAIL reset_parity_duts: got %b want 11110000",
               {ser_b, ser_c, ready_b, ready_c, busy_b, busy_c, done_b, done_c});
    else n_pass++;
    dv_a = 1'b0; dv_b = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lows = 0; busys = 0; notready = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ser_a || !ser_b || !ser_c) lows++;
      if (busy_a || busy_b || busy_c || done_a || done_b || done_c) busys++;
      if (!ready_a || !ready_b || !ready_c) notready++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (lows != 0) $display("FAIL reset_release_line: got %0d low cycles want 0", lows);
    else n_pass++;
    n_checks++;
    if (busys != 0) $display("FAIL reset_release_busy: got %0d busy/done cycles want 0", busys);
    else n_pass++;
    n_checks++;
    if (notready != 0) $display("FAIL reset_release_ready: got %0d not-ready want 0", notready);
    else n_pass++;
  endtask

  task automatic test_8n1();
    logic [15:0] exp;
    logic want, fb_got, fb_want;
    int len, bad, first_bad, nbusy, busy_at, ndone, done_at;
    exp = frame_model(9'h0A5, 8, 0, 1);
    len = frame_len(8, 0, 1);
    dv_a = 1'b1; byte_a = 8'hA5;
    capture(60, 1'b1, 1'b0);
    bad = 0; first_bad = -1; nbusy = 0; busy_at = -1; ndone = 0; done_at = -1;
    fb_got = 1'b0; fb_want = 1'b0;
    for (int k = 0; k < 60; k++) begin
      want = (k >= 2 && k < 2 + len * Cpb) ? exp[(k-2)/Cpb] : 1'b1;
      if (cap_ser_a[k] !== want) begin
        bad++;
        if (first_bad < 0) begin first_bad = k; fb_got = cap_ser_a[k]; fb_want = want; end
      end
      if (cap_busy_a[k]) begin nbusy++; if (busy_at < 0) busy_at = k; end
      if (cap_done_a[k]) begin ndone++; done_at = k; end
    end
    n_checks++;
    if (bad != 0) $display("FAIL 8n1_line: %0d bad cycles, first at %0d got %b want %b",
                           bad, first_bad, fb_got, fb_want);
    else n_pass++;
    n_checks++;
    if (nbusy != 40 || busy_at != 2)
      $display("FAIL 8n1_busy: got %0d cycles from %0d want 40 from 2", nbusy, busy_at);
    else n_pass++;
    n_checks++;
    if (ndone != 1 || done_at != 42)
      $display("FAIL 8n1_done: got %0d pulses last at %0d want 1 at 42", ndone, done_at);
    else n_pass++;
    n_checks++;
    if (cap_ready_a[1] !== 1'b0 || cap_ready_a[2] !== 1'b1)
      $display("FAIL 8n1_ready: got %b%b want 01", cap_ready_a[1], cap_ready_a[2]);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [6:0] data;
    logic [15:0] exp_b, exp_c;
    logic want_b, want_c;
    int len, bad_b, bad_c, nbusy_b, nbusy_c, ndone_b, ndone_c, done_at_b, done_at_c;
    len = frame_len(7, 2, 2);
    for (int it = 0; it < 5; it++) begin
      data = (it == 0) ? 7'h55 : 7'($urandom);
      exp_b = frame_model({2'b00, data}, 7, 2, 2);
      exp_c = frame_model({2'b00, data}, 7, 1, 2);
      dv_b = 1'b1; byte_b = data;
      capture(52, 1'b0, 1'b1);
      bad_b = 0; bad_c = 0; nbusy_b = 0; nbusy_c = 0; ndone_b = 0; ndone_c = 0;
      done_at_b = -1; done_at_c = -1;
      for (int k = 0; k < 52; k++) begin
        want_b = (k >= 2 && k < 2 + len * Cpb) ? exp_b[(k-2)/Cpb] : 1'b1;
        want_c = (k >= 2 && k < 2 + len * Cpb) ? exp_c[(k-2)/Cpb] : 1'b1;
        if (cap_ser_b[k] !== want_b) bad_b++;
        if (cap_ser_c[k] !== want_c) bad_c++;
        if (cap_busy_b[k]) nbusy_b++;
        if (cap_busy_c[k]) nbusy_c++;
        if (cap_done_b[k]) begin ndone_b++; done_at_b = k; end
        if (cap_done_c[k]) begin ndone_c++; done_at_c = k; end
      end
      n_checks++;
      if (bad_b != 0) $display("FAIL 7e2_line: data %h got %0d bad cycles want 0", data, bad_b);
      else n_pass++;
      n_checks++;
      if (bad_c != 0) $display("FAIL 7o2_line: data %h got %0d bad cycles want 0", data, bad_c);
      else n_pass++;
      n_checks++;
      if (nbusy_b != 44 || nbusy_c != 44 || ndone_b != 1 || ndone_c != 1 ||
          done_at_b != 46 || done_at_c != 46)
        $display("FAIL 7x2_status: got busy %0d/%0d done %0d@%0d/%0d@%0d want 44/44 1@46",
                 nbusy_b, nbusy_c, ndone_b, done_at_b, ndone_c, done_at_c);
      else n_pass++;
      if (it == 0) begin
        n_checks++;
        if (cap_ser_b[35] !== 1'b0 || cap_ser_c[35] !== 1'b1)
          $display("FAIL parity_bit_55: got even %b odd %b want 0 1", cap_ser_b[35],
                   cap_ser_c[35]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3];
    logic [15:0] m[3];
    logic want;
    int acc, acc_k[3], bad, nbusy, rises, ndone, ready_bad, s;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    for (int i = 0; i < 3; i++) m[i] = frame_model({1'b0, words[i]}, 8, 0, 1);
    acc = 0; dv_a = 1'b1; byte_a = words[0];
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      cap_ser_a[k] = ser_a; cap_busy_a[k] = busy_a; cap_done_a[k] = done_a;
      cap_ready_a[k] = ready_a;
      if (dv_a && ready_a) begin acc_k[acc] = k; acc++; end
      @(posedge clk); #1;
      if (acc == 3) dv_a = 1'b0;
      else byte_a = words[acc];
    end
    n_checks++;
    if (acc != 3) begin
      $display("FAIL b2b_accepts: got %0d want 3", acc);
    end else begin
      n_pass++;
      n_checks++;
      if (acc_k[0] != 0 || acc_k[1] != 2 || acc_k[2] != 42)
        $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d want 0,2,42", acc_k[0], acc_k[1],
                 acc_k[2]);
      else n_pass++;
      ready_bad = 0;
      for (int i = 0; i < 3; i++) if (cap_ready_a[acc_k[i]+1] !== 1'b0) ready_bad++;
      n_checks++;
      if (ready_bad != 0) $display("FAIL b2b_ready_drop: got %0d misses want 0", ready_bad);
      else n_pass++;
    end
    s = 2; bad = 0; nbusy = 0; rises = 0; ndone = 0;
    for (int k = 0; k < 140; k++) begin
      want = (k >= s && k < s + 120) ? m[(k-s)/40][((k-s)%40)/Cpb] : 1'b1;
      if (cap_ser_a[k] !== want) bad++;
      if (cap_busy_a[k]) nbusy++;
      if (k > 0 && cap_busy_a[k] && !cap_busy_a[k-1]) rises++;
      if (cap_done_a[k]) ndone++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL b2b_line: got %0d bad cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if (nbusy != 120 || rises != 1)
      $display("FAIL b2b_busy: got %0d cycles %0d rises want 120 1", nbusy, rises);
    else n_pass++;
    n_checks++;
    if (ndone != 3) $display("FAIL b2b_done: got %0d pulses want 3", ndone);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lows, busys, notready;
    dv_a = 1'b1; byte_a = 8'hC3;
    @(posedge clk); #1;
    dv_a = 1'b0;
    @(posedge clk); #1;
    dv_a = 1'b1; byte_a = 8'h3C;
    @(posedge clk); #1;
    dv_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_a !== 1'b0) $display("FAIL mid_buffered: got ready %b want 0", ready_a);
    else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (ser_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL mid_bit3: got line %b busy %b want 0 1", ser_a, busy_a);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ser_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL mid_async: got line %b ready %b busy %b want 1 1 0", ser_a, ready_a,
               busy_a);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0; busys = 0; notready = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!ser_a) lows++;
      if (busy_a || done_a) busys++;
      if (!ready_a) notready++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (lows != 0 || busys != 0 || notready != 0)
      $display("FAIL mid_after: got low %0d busy %0d notready %0d want 0 0 0", lows, busys,
               notready);
    else n_pass++;
    acc_q.delete();
    dec_q.delete();
  endtask

  task automatic test_backpressure();
    int waited, bad, nff, n;
    acc_q.delete();
    dec_q.delete();
    for (int k = 0; k < 1500; k++) begin
      if (ready_a) begin
        dv_a = ($urandom_range(0, 2) == 0);
        byte_a = 8'($urandom_range(0, 254));
      end else begin
        dv_a = ($urandom_range(0, 1) == 0);
        byte_a = 8'hFF;
      end
      @(posedge clk); #1;
    end
    dv_a = 1'b0;
    waited = 0;
    while ((busy_a || !ready_a || mon_busy) && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (waited >= 400) $display("FAIL bp_drain: got no idle within %0d cycles", waited);
    else n_pass++;
    n_checks++;
    if (dec_q.size() != acc_q.size() || acc_q.size() == 0)
      $display("FAIL bp_count: got %0d frames want %0d", dec_q.size(), acc_q.size());
    else n_pass++;
    n = (dec_q.size() < acc_q.size()) ? dec_q.size() : acc_q.size();
    bad = 0; nff = 0;
    for (int i = 0; i < n; i++) if (dec_q[i] !== acc_q[i]) bad++;
    foreach (dec_q[i]) if (dec_q[i] === 8'hFF) nff++;
    n_checks++;
    if (bad != 0) $display("FAIL bp_words: got %0d wrong of %0d want 0", bad, n);
    else n_pass++;
    n_checks++;
    if (nff != 0) $display("FAIL bp_ff_leak: got %0d FF frames want 0", nff);
    else n_pass++;
    n_checks++;
    if (frame_err != 0) $display("FAIL stop_bits: got %0d framing errors want 0", frame_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
